// File: rtl/vga_pkg.sv
// Definitions shared between the word buffer and the VGA display stage:
// command encoding, pattern width and published array length.
package vga_pkg;

  localparam int SLOTS = 32;
  localparam int PAT_W = 8;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_APPEND = 2'd1,
    CMD_DELETE = 2'd2,
    CMD_CLEAR  = 2'd3
  } cmd_e;

endpackage

// File: rtl/vga_word_buffer.sv
// Working word list edited by APPEND/DELETE/CLEAR, with a shadow copy that is
// published to the display only on frame start so the picture never tears.
module vga_word_buffer #(
  parameter int SLOTS = vga_pkg::SLOTS,
  parameter int CNT_W = 5,
  parameter int PAT_W = vga_pkg::PAT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_cmd,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_frame_start,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic [PAT_W-1:0] o_pattern_num [0:SLOTS-1],
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err,
  output logic             o_dirty
);
  import vga_pkg::*;

  typedef enum logic {S_RUN, S_CLEAR} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOTS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] pub_cnt_q;
  logic             dirty_q;
  logic             err_q;
  logic [PAT_W-1:0] wrk_q [0:SLOTS-1];
  logic [PAT_W-1:0] pub_q [0:SLOTS-1];

  cmd_e cmd;
  logic accept;
  logic full;
  logic empty;
  logic commit;
  logic do_append;
  logic do_delete;
  logic do_clear;

  assign cmd       = cmd_e'(i_cmd);
  assign accept    = i_valid && (state_q == S_RUN);
  assign full      = (cnt_q == LAST);
  assign empty     = (cnt_q == '0);
  assign commit    = i_frame_start && (state_q == S_RUN) && dirty_q;
  assign do_append = accept && (cmd == CMD_APPEND) && !full;
  assign do_delete = accept && (cmd == CMD_DELETE) && !empty;
  assign do_clear  = accept && (cmd == CMD_CLEAR);

  // Single write port into the working array, shared by edit and clear.
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;
  logic [PAT_W-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = i_pattern;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = idx_q;
      wr_data = '0;
    end else if (do_append) begin
      wr_en = 1'b1;
    end else if (do_delete) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q - CNT_W'(1);
      wr_data = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      idx_q     <= '0;
      pub_cnt_q <= '0;
      dirty_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && (((cmd == CMD_APPEND) && full) || ((cmd == CMD_DELETE) && empty));
      if (commit) pub_cnt_q <= cnt_q;
      case (state_q)
        S_RUN: begin
          if (do_append)      cnt_q <= cnt_q + CNT_W'(1);
          else if (do_delete) cnt_q <= cnt_q - CNT_W'(1);
          if (do_clear) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
          end
          // A command landing with the commit keeps the list marked dirty.
          if (do_append || do_delete || do_clear) dirty_q <= 1'b1;
          else if (commit)                        dirty_q <= 1'b0;
        end
        S_CLEAR: begin
          idx_q <= idx_q + CNT_W'(1);
          if (idx_q == LAST) begin
            cnt_q   <= '0;
            dirty_q <= 1'b1;
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        wrk_q[i] <= '0;
        pub_q[i] <= '0;
      end
    end else begin
      if (wr_en) wrk_q[wr_idx] <= wr_data;
      if (commit) begin
        for (int i = 0; i < SLOTS; i++) pub_q[i] <= wrk_q[i];
      end
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pub_out
    assign o_pattern_num[gi] = pub_q[gi];
  end

  assign o_ready    = (state_q == S_RUN);
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_err      = err_q;
  assign o_dirty    = dirty_q;
  assign o_word_cnt = pub_cnt_q;

endmodule

// File: tb/tb_vga_word_buffer.sv
// Self-checking bench for vga_word_buffer: vector table, directed corner
// sequences and random traffic against a list-level reference model.
module tb_vga_word_buffer;
  import vga_pkg::*;

  localparam int NS = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic [7:0]    pat = 8'd0;
  logic          fs = 1'b0;
  logic          ready;
  logic [CW-1:0] word_cnt;
  logic [7:0]    pat_o [0:NS-1];
  logic          full, empty, err, dirty;

  int checks = 0;
  int errors = 0;

  vga_word_buffer #(.SLOTS(NS), .CNT_W(CW), .PAT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_cmd(cmd),
    .i_pattern(pat), .i_frame_start(fs), .o_word_cnt(word_cnt),
    .o_pattern_num(pat_o), .o_full(full), .o_empty(empty), .o_err(err),
    .o_dirty(dirty)
  );

  always #5 clk = ~clk;

  // Reference model: the word list as a queue, the display copy as a queue.
  int m_wl[$];
  int m_pub[$];
  int m_dirty, m_err, m_clear_left;

  function automatic void model_reset();
    m_wl.delete();
    m_pub.delete();
    m_dirty = 0;
    m_err = 0;
    m_clear_left = 0;
  endfunction

  function automatic void model_step(int v, int c, int p, int f);
    int rdy;
    int nd;
    rdy = (m_clear_left == 0);
    nd = m_dirty;
    m_err = 0;
    if (f != 0 && rdy != 0 && m_dirty != 0) begin
      m_pub = m_wl;
      nd = 0;
    end
    if (v != 0 && rdy != 0) begin
      case (c)
        1: if (m_wl.size() == NS - 1) m_err = 1;
           else begin m_wl.push_back(p); nd = 1; end
        2: if (m_wl.size() == 0) m_err = 1;
           else begin void'(m_wl.pop_back()); nd = 1; end
        3: begin m_clear_left = NS; nd = 1; end
        default: ;
      endcase
    end else if (rdy == 0) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        m_wl.delete();
        nd = 1;
      end
    end
    m_dirty = nd;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int bad;
    int e;
    bad = -1;
    check("ready", int'(ready), int'(m_clear_left == 0));
    check("full", int'(full), int'(m_wl.size() == NS - 1));
    check("empty", int'(empty), int'(m_wl.size() == 0));
    check("err", int'(err), m_err);
    check("dirty", int'(dirty), m_dirty);
    check("word_cnt", int'(word_cnt), m_pub.size());
    for (int i = 0; i < NS; i++) begin
      e = (i < m_pub.size()) ? m_pub[i] : 0;
      if (int'(pat_o[i]) != e && bad < 0) bad = i;
    end
    check("pattern_first_bad_slot", bad, -1);
  endtask

  task automatic cycle(int v, int c, int p, int f);
    valid = v[0];
    cmd   = c[1:0];
    pat   = p[7:0];
    fs    = f[0];
    @(posedge clk);
    model_step(v, c, p, f);
    #1;
    valid = 1'b0;
    cmd   = 2'd0;
    fs    = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int v, c, p, f;
    int cnt, rdy, full, empty, err, dirty, p0, p1;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int busy;
    int r, c, v, f;

    //            v  c  p  f   cnt rdy ful emp err dty p0 p1
    tbl[0]  = '{1, 1, 2, 0,   0,  1,  0,  0,  0,  1,  0, 0};
    tbl[1]  = '{1, 1, 3, 0,   0,  1,  0,  0,  0,  1,  0, 0};
    tbl[2]  = '{0, 0, 0, 1,   2,  1,  0,  0,  0,  0,  2, 3};
    tbl[3]  = '{1, 2, 0, 0,   2,  1,  0,  0,  0,  1,  2, 3};
    tbl[4]  = '{1, 2, 0, 0,   2,  1,  0,  1,  0,  1,  2, 3};
    tbl[5]  = '{0, 0, 0, 1,   0,  1,  0,  1,  0,  0,  0, 0};
    tbl[6]  = '{1, 2, 0, 0,   0,  1,  0,  1,  1,  0,  0, 0};
    tbl[7]  = '{1, 0, 0, 0,   0,  1,  0,  1,  0,  0,  0, 0};
    tbl[8]  = '{1, 1, 7, 0,   0,  1,  0,  0,  0,  1,  0, 0};
    tbl[9]  = '{1, 2, 0, 0,   0,  1,  0,  1,  0,  1,  0, 0};
    tbl[10] = '{0, 0, 0, 1,   0,  1,  0,  1,  0,  0,  0, 0};
    tbl[11] = '{0, 0, 0, 1,   0,  1,  0,  1,  0,  0,  0, 0};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].p, tbl[i].f);
      check($sformatf("vec%0d_word_cnt", i), int'(word_cnt), tbl[i].cnt);
      check($sformatf("vec%0d_ready", i), int'(ready), tbl[i].rdy);
      check($sformatf("vec%0d_full", i), int'(full), tbl[i].full);
      check($sformatf("vec%0d_empty", i), int'(empty), tbl[i].empty);
      check($sformatf("vec%0d_err", i), int'(err), tbl[i].err);
      check($sformatf("vec%0d_dirty", i), int'(dirty), tbl[i].dirty);
      check($sformatf("vec%0d_pat0", i), int'(pat_o[0]), tbl[i].p0);
      check($sformatf("vec%0d_pat1", i), int'(pat_o[1]), tbl[i].p1);
      $display("vec %0d cmd=%0d fs=%0d cnt=%0d dirty=%0d", i, tbl[i].c, tbl[i].f, word_cnt, dirty);
    end

    // Fill to capacity, overflow, publish.
    do_reset();
    for (int i = 0; i < NS - 1; i++) cycle(1, 1, 8'hA5, 0);
    check("fill_full", int'(full), 1);
    cycle(1, 1, 8'h11, 0);
    check("overflow_err", int'(err), 1);
    cycle(0, 0, 0, 0);
    check("overflow_err_drop", int'(err), 0);
    cycle(0, 0, 0, 1);
    check("full_commit_cnt", int'(word_cnt), 31);
    check("full_commit_pat30", int'(pat_o[30]), 8'hA5);
    check("full_commit_pat31", int'(pat_o[31]), 0);
    $display("seq full: cnt=%0d pat31=%0d", word_cnt, pat_o[31]);

    // CLEAR with an ignored frame start during the clear.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 10 + i, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 3, 0, 0);
    busy = (ready == 1'b0) ? 1 : 0;
    for (int k = 0; k < 40 && ready == 1'b0; k++) begin
      cycle(1, 1, 99, (k == 2) ? 1 : 0);
      if (ready == 1'b0) busy++;
      check("clear_pub_cnt_held", int'(word_cnt), 5);
    end
    check("clear_busy_cycles", busy, NS);
    cycle(0, 0, 0, 1);
    check("clear_commit_cnt", int'(word_cnt), 0);
    check("clear_commit_pat0", int'(pat_o[0]), 0);
    $display("seq clear: busy=%0d cnt=%0d", busy, word_cnt);

    // Command coinciding with commit.
    do_reset();
    cycle(1, 1, 1, 0);
    cycle(1, 1, 9, 1);
    check("same_cycle_cnt", int'(word_cnt), 1);
    check("same_cycle_dirty", int'(dirty), 1);
    cycle(0, 0, 0, 1);
    check("same_cycle_next_cnt", int'(word_cnt), 2);
    check("same_cycle_next_pat1", int'(pat_o[1]), 9);
    $display("seq same-cycle: cnt=%0d pat1=%0d", word_cnt, pat_o[1]);

    // Asynchronous reset in the middle of a clear.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 40 + i, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 3, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_ready", int'(ready), 1);
    check("async_rst_cnt", int'(word_cnt), 0);
    check("async_rst_pat0", int'(pat_o[0]), 0);
    check("async_rst_empty", int'(empty), 1);
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", int'(ready), 1);
    cycle(0, 0, 0, 1);
    $display("seq mid-clear reset: ready=%0d cnt=%0d", ready, word_cnt);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      c = (r < 55) ? 1 : (r < 80) ? 2 : (r < 83) ? 3 : 0;
      v = ($urandom_range(0, 9) != 0) ? 1 : 0;
      f = ($urandom_range(0, 7) == 0) ? 1 : 0;
      cycle(v, c, $urandom_range(0, 255), f);
    end
    $display("random: final list size=%0d published=%0d", m_wl.size(), m_pub.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
